// File: rtl/adc_pkg.sv
// Shared types and constants for the SAR ADC sequencer.
// The settle-counter width bounds SETTLE_CYCLES to 1..15 when SAR_SETTLE_EN is defined.
package adc_pkg;

   localparam int ADC_WIDTH    = 8;
   localparam int SETTLE_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_BIT,
      ST_DONE
   } sar_state_t;

endpackage

// File: rtl/sar_trial_reg.sv
// Trial/result register for successive approximation: loads the MSB, then per decision
// keeps or clears the current bit and sets the next lower one.
module sar_trial_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             decide_i,
   input  logic             cmp_gt_i,
   output logic [WIDTH-1:0] trial_o,
   output logic [WIDTH-1:0] trial_next_o,
   output logic             last_o
);

   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] trial_reg;
   logic [WIDTH-1:0] trial_next;
   logic [WIDTH-1:0] mask_reg;
   logic [WIDTH-1:0] mask_next;

   // mask_reg is one-hot on the bit currently under test
   always_comb begin
      trial_next = trial_reg;
      mask_next  = mask_reg;
      if (load_i) begin
         trial_next = MSB_ONLY;
         mask_next  = MSB_ONLY;
      end else if (decide_i) begin
         mask_next  = mask_reg >> 1;
         trial_next = (cmp_gt_i ? trial_reg : (trial_reg & ~mask_reg)) | mask_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trial_reg <= '0;
         mask_reg  <= '0;
      end else begin
         trial_reg <= trial_next;
         mask_reg  <= mask_next;
      end
   end

   assign trial_o      = trial_reg;
   assign trial_next_o = trial_next;
   assign last_o       = mask_reg[0];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion sequencer driving an external strict (Vin > Vref) comparator.
// Optional SAR_SETTLE_EN adds SETTLE_CYCLES hold cycles per bit before sampling cmp_gt_i.
module sar_adc_ctrl
   import adc_pkg::*;
#(
   parameter int WIDTH         = ADC_WIDTH,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             cmp_gt_i,
   output logic             sample_o,
   output logic [WIDTH-1:0] vref_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   sar_state_t       state_reg;
   logic             bit_final;
   logic             load;
   logic             decide;
   logic             last_bit;
   logic [WIDTH-1:0] trial;
   logic [WIDTH-1:0] trial_next;

`ifdef SAR_SETTLE_EN
   logic [SETTLE_CNT_W-1:0] settle_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt_reg <= '0;
      end else if (state_reg != ST_BIT || bit_final) begin
         settle_cnt_reg <= '0;
      end else begin
         settle_cnt_reg <= settle_cnt_reg + SETTLE_CNT_W'(1);
      end
   end

   assign bit_final = (settle_cnt_reg == SETTLE_CNT_W'(SETTLE_CYCLES));
`else
   logic unused_settle;
   assign unused_settle = (SETTLE_CYCLES != 0);
   assign bit_final     = 1'b1;
`endif

   assign load   = (state_reg == ST_SAMPLE);
   assign decide = (state_reg == ST_BIT) && bit_final;

   sar_trial_reg #(
      .WIDTH (WIDTH)
   ) u_trial (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load),
      .decide_i     (decide),
      .cmp_gt_i     (cmp_gt_i),
      .trial_o      (trial),
      .trial_next_o (trial_next),
      .last_o       (last_bit)
   );

   // vref is trial-1 so the strict comparator answers "Vin >= trial"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         sample_o  <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         vref_o    <= '0;
         result_o  <= '0;
      end else begin
         sample_o <= 1'b0;
         done_o   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start_i) begin
                  state_reg <= ST_SAMPLE;
                  sample_o  <= 1'b1;
                  busy_o    <= 1'b1;
               end
            end
            ST_SAMPLE: begin
               state_reg <= ST_BIT;
               vref_o    <= trial_next - WIDTH'(1);
            end
            ST_BIT: begin
               if (decide) begin
                  if (last_bit) begin
                     state_reg <= ST_DONE;
                     busy_o    <= 1'b0;
                     done_o    <= 1'b1;
                     vref_o    <= '0;
                     result_o  <= trial_next;
                  end else begin
                     vref_o <= trial_next - WIDTH'(1);
                  end
               end
            end
            ST_DONE: begin
               if (start_i) begin
                  state_reg <= ST_SAMPLE;
                  sample_o  <= 1'b1;
                  busy_o    <= 1'b1;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   logic unused_trial;
   assign unused_trial = ^trial;

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Successive-approximation sequencer that time-shares the existing 8-bit `comparator` (strict Vin > Vref, output `A_grt_B`) to convert one analog-sampled code per request. Drives the comparator reference with a binary-search trial code, captures the comparator decision each step, and returns the converted code with a done pulse. It sits between the sample/hold front end and the ADC result consumer. It is the low-area alternative to the flash comparator bank.

## Interface
- `WIDTH`, 8: resolution in bits; also the width of `vref_o` and `result_o`.
- `SETTLE_CYCLES`, 1: extra hold cycles per bit before sampling `cmp_gt_i`. Used only when `SAR_SETTLE_EN` is defined; legal range 1..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  conversion request. Sampled only in IDLE or DONE.
- `cmp_gt_i`  in  1  comparator `A_grt_B`. 1 iff Vin > `vref_o`; combinational in the same cycle.
- `sample_o`  out  1  one-cycle pulse commanding sample/hold to capture Vin.
- `vref_o`  out  WIDTH  registered reference to the comparator.
- `busy_o`  out  1  high from SAMPLE through the last bit decision.
- `done_o`  out  1  one-cycle pulse; `result_o` is valid from this cycle onward.
- `result_o`  out  WIDTH  last completed conversion; held until the next done.

## Operation
- States:
  - IDLE: `start_i` → SAMPLE.
  - SAMPLE: 1 cycle, `sample_o`=1; go to BIT with bit index = WIDTH-1 and trial = 1<<(WIDTH-1).
  - BIT: drive `vref_o` = trial − 1 (WIDTH bits; trial is never 0, so no underflow). At the end of the bit's last cycle, keep the current bit if `cmp_gt_i`=1 (i.e. Vin ≥ trial), else clear it. Then set the next lower bit in trial. After bit 0, go to DONE.
  - DONE: 1 cycle, `done_o`=1; load `result_o` ← final trial; `start_i` → SAMPLE (back-to-back), else → IDLE.
- Result equals Vin exactly for 0..2^WIDTH−1. This follows from the strict comparator plus the trial−1 reference.
- `start_i` is ignored in SAMPLE and BIT; no queueing.
- `vref_o` = 0 in IDLE, SAMPLE and DONE.
- Reset values: `sample_o`=0, `busy_o`=0, `done_o`=0, `vref_o`=0, `result_o`=0, state IDLE.
- Reset mid-conversion: immediate abort to the reset values. No `done_o` is emitted, and the old `result_o` is lost (cleared to 0).

## Timing
- `start_i` is sampled high at edge 0. SAMPLE occupies cycle 1. Bit k (MSB first) occupies cycles 2.. with (1+S) cycles per bit, where S = 0 without the macro and S = SETTLE_CYCLES with it.
- `done_o` is high in cycle 2 + WIDTH·(1+S); default: cycle 10.
- `busy_o` is high in cycles 1 .. 1 + WIDTH·(1+S) and low in DONE.
- `cmp_gt_i` is sampled only on the final cycle of each bit. Values in earlier settle cycles are ignored.
- Back-to-back: `start_i` high during DONE gives SAMPLE in the next cycle. Throughput is one conversion per 2 + WIDTH·(1+S) cycles.

## Configuration
- `SAR_SETTLE_EN` defined: a per-bit settle counter holds `vref_o` for SETTLE_CYCLES additional cycles before sampling. This accommodates reference DAC settling.
- Not defined: no counter logic; exactly one cycle per bit; `SETTLE_CYCLES` is ignored.

## Structure
- Shared package `adc_pkg` holds:
  - the state enum (IDLE, SAMPLE, BIT, DONE);
  - `ADC_WIDTH` = 8;
  - the settle-counter width constant.
- One sub-module: `sar_trial_reg`. It holds the trial/result shift-and-decide register: load MSB, keep/clear the current bit, set the next bit. The top-level FSM drives it.
- The `comparator` is external: the top level wires `vref_o`/`cmp_gt_i` to it.

## Test plan
- Bench models the comparator as Vin > Vref.
- Vin = 167, start → `vref_o` sequence 127, 191, 159, 175, 167, 163, 165, 166. `done_o` in cycle 10 with `result_o` = 167; `sample_o` only in cycle 1.
- Vin = 85 (equality with trial code) → `result_o` = 85. Vin = 0 → 0, `vref_o` = 127, 63, 31, 15, 7, 3, 1, 0. Vin = 255 → 255.
- `start_i` pulsed in cycle 4 of a Vin = 38 conversion → ignored. Single `done_o` with 38. `start_i` held high through DONE → next SAMPLE in cycle 11.
- `rst_n` low in cycle 6 → all outputs 0 asynchronously, no `done_o`. Fresh start after release converts correctly.
- `SAR_SETTLE_EN` with SETTLE_CYCLES = 2, Vin = 105 → each `vref_o` held 3 cycles. Toggling `cmp_gt_i` in settle cycles has no effect. `done_o` in cycle 26 with `result_o` = 105.
